// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC control sequencer: opcode constants, sequencer
// states, instruction classes and the strobe bundle driven toward the datapath.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_e;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, ba_out, inport_out, c_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outport_in;
    logic gra, grb, grc, con_in, inc_pc, read, write, r_in, r_out;
  } strobes_t;

  // Undefined opcodes fall into C_NOP: fetch only.
  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:    return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:   return C_IMM;
      OP_MUL, OP_DIV:             return C_MULDIV;
      OP_NEG, OP_NOT:             return C_UNARY;
      OP_LDI:                     return C_LDI;
      OP_LD:                      return C_LD;
      OP_ST:                      return C_ST;
      OP_BR:                      return C_BR;
      OP_JR:                      return C_JR;
      OP_IN:                      return C_IN;
      OP_OUT:                     return C_OUT;
      OP_MFHI:                    return C_MFHI;
      OP_MFLO:                    return C_MFLO;
      OP_HALT:                    return C_HALT;
      default:                    return C_NOP;
    endcase
  endfunction

  function automatic state_e final_step(input op_class_e c);
    case (c)
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: return S_T3;
      C_UNARY:                           return S_T4;
      C_ALU, C_IMM, C_LDI:               return S_T5;
      C_MULDIV, C_BR:                    return S_T6;
      C_LD, C_ST:                        return S_T7;
      default:                           return S_T2;
    endcase
  endfunction

  function automatic state_e next_step(input state_e s);
    case (s)
      S_T0:    return S_T1;
      S_T1:    return S_T2;
      S_T2:    return S_T3;
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_T0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired control sequencer: one step per clock, strobes decoded from the
// present step and IR[31:27]. IR is not latched; it must hold through execute.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
  output logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
  output logic        Gra, Grb, Grc, CONin, IncPC, Read, Write, Rin, Rout
);

  state_e    state_q, state_d;
  op_class_e op_class;
  strobes_t  s;
  logic      unused_ir;

  assign op_class  = classify(IR[31:27]);
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: begin
        if (state_q == S_T2 && op_class == C_HALT)  state_d = S_HALT;
        else if (state_q == final_step(op_class))    state_d = Stop ? S_HALT : S_T0;
        else                                         state_d = next_step(state_q);
      end
    endcase
  end

  always_comb begin
    s = '0;
    case (state_q)
      S_T0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.pc_in = 1'b1; end
      S_T1: begin s.read = 1'b1; s.mdr_in = 1'b1; end
      S_T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      S_T3: begin
        case (op_class)
          C_ALU, C_IMM:    begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
          C_MULDIV:        begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
          C_UNARY:         begin s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; end
          C_LDI, C_LD, C_ST: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
          C_BR:            begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
          C_JR:            begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
          C_IN:            begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_OUT:           begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; end
          C_MFHI:          begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_MFLO:          begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_ALU:                    begin s.grc = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST: begin s.c_out = 1'b1; s.z_in = 1'b1; end
          C_MULDIV:                 begin s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; end
          C_UNARY:                  begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_BR:                     begin s.pc_out = 1'b1; s.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_ALU, C_IMM, C_LDI: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_MULDIV:            begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
          C_LD, C_ST:          begin s.zlow_out = 1'b1; s.mar_in = 1'b1; end
          C_BR:                begin s.c_out = 1'b1; s.z_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          C_MULDIV: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
          C_LD:     begin s.read = 1'b1; s.mdr_in = 1'b1; end
          C_ST:     begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
          C_BR:     begin s.zlow_out = 1'b1; s.pc_in = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          C_LD:    begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          C_ST:    s.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run = (state_q != S_RST) && (state_q != S_HALT);

  assign PCout     = s.pc_out;
  assign Zhighout  = s.zhigh_out;
  assign Zlowout   = s.zlow_out;
  assign MDRout    = s.mdr_out;
  assign HIout     = s.hi_out;
  assign LOout     = s.lo_out;
  assign BAout     = s.ba_out;
  assign InPortout = s.inport_out;
  assign Cout      = s.c_out;
  assign MARin     = s.mar_in;
  assign Zin       = s.z_in;
  assign PCin      = s.pc_in;
  assign MDRin     = s.mdr_in;
  assign IRin      = s.ir_in;
  assign Yin       = s.y_in;
  assign HIin      = s.hi_in;
  assign LOin      = s.lo_in;
  assign OutPortin = s.outport_in;
  assign Gra       = s.gra;
  assign Grb       = s.grb;
  assign Grc       = s.grc;
  assign CONin     = s.con_in;
  assign IncPC     = s.inc_pc;
  assign Read      = s.read;
  assign Write     = s.write;
  assign Rin       = s.r_in;
  assign Rout      = s.r_out;

endmodule
